// File: rtl/unco_sweep_ctrl.sv
// Frequency-sweep scheduler feeding the NCO phase-increment AXI-Stream input.
// Steps start->stop in clamped steps. Each value is held for a number of accepted beats.
module unco_sweep_ctrl #(
  parameter int INC_WIDTH   = 32,
  parameter int DWELL_WIDTH = 24,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   aclk,
  input  logic                   arst_n,
  input  logic [INC_WIDTH-1:0]   cfg_start_inc,
  input  logic [INC_WIDTH-1:0]   cfg_stop_inc,
  input  logic [INC_WIDTH-1:0]   cfg_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [1:0]             cfg_mode,
  input  logic                   start,
  input  logic                   abort,
  output logic [INC_WIDTH-1:0]   m_axis_inc_tdata,
  output logic                   m_axis_inc_tvalid,
  input  logic                   m_axis_inc_tready,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   sweep_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Reset asserts asynchronously but releases only on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t                 state;
  logic [INC_WIDTH-1:0]   cur;
  logic                   tvalid_r, busy_r, done_r;
  logic [CNT_WIDTH-1:0]   count;
  logic [DWELL_WIDTH-1:0] dwell_cnt, lat_dwell;
  logic [INC_WIDTH-1:0]   lat_start, lat_stop, lat_step;
  logic [1:0]             lat_mode;
  logic                   dir_up, ret_leg;

  function automatic logic [INC_WIDTH-1:0] advance(
    input logic [INC_WIDTH-1:0] v,
    input logic [INC_WIDTH-1:0] tgt,
    input logic [INC_WIDTH-1:0] stp,
    input logic                 up
  );
    logic [INC_WIDTH:0] sum, diff;
    sum  = {1'b0, v} + {1'b0, stp};
    diff = {1'b0, v} - {1'b0, stp};
    if (up) return (sum >= {1'b0, tgt}) ? tgt : sum[INC_WIDTH-1:0];
    else    return ((v < stp) || (diff <= {1'b0, tgt})) ? tgt : diff[INC_WIDTH-1:0];
  endfunction

  logic                 beat, last_beat, up_eff, at_tgt;
  logic [INC_WIDTH-1:0] tgt, rev_tgt, nxt_fwd, nxt_rev;

  // The return leg of a triangle flips both the target and the direction.
  always_comb begin
    beat      = (state == RUN) && m_axis_inc_tready;
    last_beat = (dwell_cnt == DWELL_WIDTH'(1));
    up_eff    = dir_up ^ ret_leg;
    tgt       = ret_leg ? lat_start : lat_stop;
    rev_tgt   = ret_leg ? lat_stop  : lat_start;
    at_tgt    = (cur == tgt);
    nxt_fwd   = advance(cur, tgt, lat_step, up_eff);
    nxt_rev   = advance(cur, rev_tgt, lat_step, !up_eff);
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      tvalid_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      count     <= '0;
      dwell_cnt <= '0;
      lat_dwell <= '0;
      lat_start <= '0;
      lat_stop  <= '0;
      lat_step  <= '0;
      lat_mode  <= '0;
      dir_up    <= 1'b0;
      ret_leg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (start && !abort) begin
            lat_start <= cfg_start_inc;
            lat_stop  <= cfg_stop_inc;
            lat_step  <= cfg_step;
            lat_mode  <= cfg_mode;
            lat_dwell <= (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
            dwell_cnt <= (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
            dir_up    <= (cfg_start_inc <= cfg_stop_inc);
            ret_leg   <= 1'b0;
            cur       <= cfg_start_inc;
            count     <= '0;
            tvalid_r  <= 1'b1;
            busy_r    <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            tvalid_r <= 1'b0;
            busy_r   <= 1'b0;
            state    <= IDLE;
          end else if (beat) begin
            if (!last_beat) begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end else begin
              dwell_cnt <= lat_dwell;
              if (!at_tgt) begin
                cur <= nxt_fwd;
              end else begin
                case (lat_mode)
                  2'd1: begin
                    count <= count + 1'b1;
                    cur   <= lat_start;
                  end
                  2'd2: begin
                    // A zero-length triangle counts every dwell period.
                    if (lat_start == lat_stop) begin
                      count <= count + 1'b1;
                    end else begin
                      ret_leg <= !ret_leg;
                      cur     <= nxt_rev;
                      if (ret_leg) count <= count + 1'b1;
                    end
                  end
                  default: begin
                    count    <= count + 1'b1;
                    tvalid_r <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    state    <= DONE;
                  end
                endcase
              end
            end
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axis_inc_tdata  = cur;
  assign m_axis_inc_tvalid = tvalid_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign sweep_count       = count;

endmodule

// File: doc/unco_sweep_ctrl.md
Name: unco_sweep_ctrl

Overview:
- Frequency-sweep scheduler that drives the phase-increment AXI-Stream input of the NCO feeding the MASH DAC path.
- Steps the increment from a start value to a stop value in fixed steps. Each value is held for a programmable number of accepted beats.
- Sweep modes: single-shot, repeating sawtooth, or triangle.
- Configuration is latched at start. Abort returns the block to idle immediately.

Parameters:
- INC_WIDTH, 32, width of phase increment (matches NCO accumulator width)
- DWELL_WIDTH, 24, width of dwell counter
- CNT_WIDTH, 16, width of completed-sweep counter

Ports:
- aclk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- cfg_start_inc  in  INC_WIDTH  first increment of sweep
- cfg_stop_inc  in  INC_WIDTH  final increment of sweep
- cfg_step  in  INC_WIDTH  unsigned step magnitude
- cfg_dwell  in  DWELL_WIDTH  accepted beats per value (0 treated as 1)
- cfg_mode  in  2  0=single, 1=repeat sawtooth, 2=triangle, 3=reserved (behaves as single)
- start  in  1  single-cycle start request
- abort  in  1  single-cycle abort request
- m_axis_inc_tdata  out  INC_WIDTH  current phase increment to NCO
- m_axis_inc_tvalid  out  1  increment valid
- m_axis_inc_tready  in  1  NCO ready (beat accepted when tvalid&&tready)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on single-sweep completion
- sweep_count  out  CNT_WIDTH  completed sweeps since start, wraps

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; tdata=0, tvalid=0, busy=0, done=0, sweep_count=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - tvalid=0; tdata holds last emitted value.
  - start=1 and abort=0 → latch all cfg_*; direction up if start_inc<=stop_inc else down; sweep_count=0; go to RUN.
  - Latency: at cycle N+1 after the start cycle, tdata=start_inc, tvalid=1, busy=1.
- RUN:
  - tvalid=1 and busy=1 every cycle.
  - Dwell counter decrements only on accepted beats. It reloads with max(cfg_dwell,1) on every value change.
  - When the last dwell beat of a value is accepted, the next value appears the following cycle.
- Next-value arithmetic:
  - Computed with INC_WIDTH+1 bits, so there is no wrap.
  - Moving up: next=cur+step. If next>=target, emit target exactly (clamp).
  - Moving down: next=cur-step. If cur<step or next<=target, emit target.
  - Target is stop_inc, or start_inc on the return leg of triangle mode.
- End of leg (last dwell beat of the target value accepted):
  - single: go to DONE.
  - repeat: sweep_count++, next value = start_inc.
  - triangle: at stop_inc, reverse direction and target start_inc. At start_inc, sweep_count++, reverse, target stop_inc. Endpoint values are not repeated on reversal.
- DONE: lasts one cycle. done=1, sweep_count++, tvalid=0, busy=0, tdata holds stop_inc. Then IDLE.
- Degenerate configurations:
  - start_inc==stop_inc, single mode: emit one value for its dwell, then DONE.
  - start_inc==stop_inc, repeat/triangle: hold value; sweep_count increments every dwell period.
  - cfg_step==0 and start!=stop: value holds at start_inc indefinitely; only abort exits.
- abort:
  - From RUN: next cycle is IDLE; tvalid=0, busy=0, no done pulse. tdata and sweep_count hold.
  - abort in IDLE has no effect. start and abort in the same IDLE cycle: abort wins, start ignored.
- start while in RUN is ignored.
- cfg_* changes after latch have no effect until the next start.
- Backpressure: tready=0 freezes the dwell count and value, with tdata/tvalid stable (AXI-S rules).
- Reset asserted mid-sweep: immediate return to reset values.

Test Plan:
- Single up: start=100, stop=130, step=10, dwell=2, tready=1 → tdata 100,100,110,110,120,120,130,130; then done pulse, tvalid=0, sweep_count=1.
- Clamp and down: start=50, stop=3, step=20, dwell=1, single → tdata 50,30,10,3; done after the 3 is accepted; no underflow.
- Triangle: start=0, stop=4, step=2, dwell=1 → 0,2,4,2,0,2,4…; sweep_count increments to 1 at the second 0 and to 2 at the third 0.
- Backpressure: single 0→2 step 1 dwell=2, tready toggled 1,0,0,1,… → each value held for exactly 2 accepted beats; tdata stable while tready=0.
- Abort mid-RUN in repeat mode after 5 beats → next cycle tvalid=0, busy=0, done=0; tdata holds its last value. A start 3 cycles later restarts at cfg_start_inc with sweep_count=0.
- Reset mid-sweep (arst_n low asynchronously between edges) → outputs 0 immediately. start+abort in the same cycle while IDLE → stays IDLE.
